vga_px_arbiter: RTL and testbench
=================================

Name: vga_px_arbiter

Overview:
- Shares the single VGA pixel-buffer Avalon master among N_REQ pixel writers, for example the game command writer, the clear-screen sweeper and a border/overlay painter.
- Uses round-robin arbitration and issues one write transaction at a time.
- Holds address and data stable until the slave drops waitrequest, then returns a one-cycle ack to the winning requester.
- Sits between the snake game core and the vga_px master conduit.

Parameters:
N_REQ, 3, number of requesters (1..8)
ADDR_W, 32, pixel address width
DATA_W, 16, pixel colour width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester write request; level, held until ack
req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  N_REQ*DATA_W  packed colours, same packing
ack  out  N_REQ  one-cycle pulse: requester i's write accepted
busy  out  1  high while a transaction is in flight (WRITE or ACK state)
grant_id  out  3  index of current or last winner
vga_px_address  out  ADDR_W  Avalon address
vga_px_write  out  1  Avalon write
vga_px_writedata  out  DATA_W  Avalon writedata
vga_px_read  out  1  tied 0
vga_px_waitrequest  in  1  Avalon waitrequest

Behaviour:
- Reset (async, reset_n=0): state=IDLE, rr_ptr=0, grant_id=0, ack=0, busy=0, vga_px_write=0, vga_px_address=0, vga_px_writedata=0. All outputs are registered.
- FSM states: IDLE, WRITE, ACK.
- IDLE, req==0: remain in IDLE; outputs unchanged except write=0.
- IDLE, req!=0:
  - winner = first set bit of req scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Register vga_px_address and vga_px_writedata from the winner's slice.
  - Set vga_px_write=1, grant_id=winner; go to WRITE.
  - The first write cycle is one cycle after req is sampled.
- WRITE: address, data and write are held constant.
  - The transfer completes in the first WRITE cycle where vga_px_waitrequest=0.
  - On completion: write<=0, ack[winner]<=1, rr_ptr<=(winner+1) mod N_REQ; go to ACK.
- ACK: ack<=0; go to IDLE.
  - Requester contract: drop req, or present new addr/data, in the cycle ack is high.
  - ACK guarantees req is never resampled before the requester has seen ack.
- Minimum cost is 3 cycles per write with zero wait states. Each extra waitrequest cycle adds one cycle.
- Arbitration fairness: the most recent winner gets lowest priority. With all requesters asserting continuously, grants cycle 0,1,2,0,...
- A request is considered only in IDLE. Requests arriving in WRITE/ACK wait; none are lost while held.
- Requester deasserts req while not granted: it is simply not selected.
- Granted requester deasserts req mid-WRITE: ignored; the write completes and ack still pulses.
- Changes to the winner's addr/data during WRITE are ignored, because the values are latched.
- Reset asserted during WRITE: vga_px_write drops asynchronously and no ack is issued. Requesters must reissue after reset.
- N_REQ=1: degenerates to a registered pass-through with the same 3-cycle handshake.
- busy = (state != IDLE).

Optional Feature:
- Macro VGA_PX_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. If req[0]=1 in IDLE, it wins regardless of rr_ptr. Round-robin applies only among requesters 1..N_REQ-1. rr_ptr is not updated when requester 0 wins.
- Intended use: gives the clear-screen engine precedence over game writes.
- Undefined: pure round-robin as above.

Test Plan:
- Single request: req=3'b001, addr0=0x0800_1234, data0=0xF800, waitrequest=0 → write=1 with those values one cycle later; ack=3'b001 the next cycle; busy low after ACK.
- Wait states: req=3'b010, waitrequest held 1 for 4 cycles → address/data/write stable 5 cycles; ack[1] pulses exactly once, the cycle after waitrequest=0.
- Fairness: req=3'b111 held, zero-wait slave, auto-reissue after each ack → grant_id sequence 0,1,2,0,1,2; one write per 3 cycles.
- Late arrival: req[2] rises during WRITE for requester 0 → requester 2 is granted on the next IDLE; no ack to requester 2 before its write completes.
- Reset mid-write: assert reset_n=0 while write=1 and waitrequest=1 → write=0 immediately, ack=0; after release, state IDLE and rr_ptr=0.
- VGA_PX_ARB_PRIO0_EN defined: req=3'b111 held continuously → requester 0 wins every time. With req[0] released, requesters 1 and 2 alternate.

Source files
------------

// File: rtl/vga_px_arbiter.sv
// vga_px_arbiter
// Round-robin arbiter that shares one Avalon-MM write master (the VGA pixel
// buffer conduit) among N_REQ pixel writers. One write is in flight at a time.
// The winner's address/colour are latched and held until waitrequest drops,
// then a one-cycle ack goes back to the winner.
//
// Optional build macro: VGA_PX_ARB_PRIO0_EN
//   defined   - requester 0 has absolute priority; round-robin among 1..N_REQ-1
//   undefined - pure round-robin across all requesters
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req[N_REQ]            level requests, held until ack
//   req_addr, req_data    packed per-requester address / colour (slot i at i*W)
//   ack[N_REQ]            one-cycle accept pulse to the winner
//   busy                  transaction in flight (WRITE or ACK)
//   grant_id[3]           index of current or last winner
//   vga_px_*              Avalon-MM master (write-only; read tied low)
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its address/colour
// WRITE | write asserted, held until waitrequest is low
// ACK   | ack pulse cycle; keeps req from being resampled before it is seen

module vga_px_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [ADDR_W-1:0]         vga_px_address,
    output logic                      vga_px_write,
    output logic [DATA_W-1:0]         vga_px_writedata,
    output logic                      vga_px_read,
    input  logic                      vga_px_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [2:0]              rr_ptr, rr_ptr_nxt;
    logic [2:0]              grant_nxt;
    logic [ADDR_W-1:0]       addr_nxt;
    logic [DATA_W-1:0]       data_nxt;
    logic                    write_nxt;
    logic [N_REQ-1:0]        ack_nxt;
    logic                    busy_nxt;

    logic [N_REQ-1:0]        rr_req;
    logic [N_REQ-1:0]        req_sh;
    logic [2:0]              win;
    logic                    win_vld;
    logic [N_REQ*ADDR_W-1:0] addr_sh;
    logic [N_REQ*DATA_W-1:0] data_sh;
    int                      idx;

    assign vga_px_read = 1'b0;

    // Winner search: first set bit scanning from rr_ptr upward, modulo N_REQ.
    always_comb begin
        idx     = 0;
        req_sh  = '0;
        win     = 3'd0;
        win_vld = 1'b0;
`ifdef VGA_PX_ARB_PRIO0_EN
        // Requester 0 is taken out of the rotation; it wins outright below.
        rr_req  = req & ~N_REQ'(1);
`else
        rr_req  = req;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            idx    = (int'(rr_ptr) + k) % N_REQ;
            req_sh = rr_req >> idx;
            if (!win_vld && req_sh[0]) begin
                win     = 3'(idx);
                win_vld = 1'b1;
            end
        end
`ifdef VGA_PX_ARB_PRIO0_EN
        if (req[0]) begin
            win     = 3'd0;
            win_vld = 1'b1;
        end
`endif
    end

    assign addr_sh = req_addr >> (int'(win) * ADDR_W);
    assign data_sh = req_data >> (int'(win) * DATA_W);

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        addr_nxt   = vga_px_address;
        data_nxt   = vga_px_writedata;
        write_nxt  = vga_px_write;
        ack_nxt    = '0;
        case (state)
            ST_IDLE: begin
                write_nxt = 1'b0;
                if (win_vld) begin
                    grant_nxt = win;
                    addr_nxt  = addr_sh[ADDR_W-1:0];
                    data_nxt  = data_sh[DATA_W-1:0];
                    write_nxt = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!vga_px_waitrequest) begin
                    write_nxt = 1'b0;
                    ack_nxt   = N_REQ'(1) << grant_id;
                    state_nxt = ST_ACK;
`ifdef VGA_PX_ARB_PRIO0_EN
                    // Requester 0 only ever wins by priority, so it never moves the pointer.
                    if (grant_id != 3'd0)
                        rr_ptr_nxt = (grant_id == 3'(N_REQ-1)) ? 3'd0 : grant_id + 3'd1;
`else
                    rr_ptr_nxt = (grant_id == 3'(N_REQ-1)) ? 3'd0 : grant_id + 3'd1;
`endif
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                write_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            rr_ptr           <= 3'd0;
            grant_id         <= 3'd0;
            ack              <= '0;
            busy             <= 1'b0;
            vga_px_write     <= 1'b0;
            vga_px_address   <= '0;
            vga_px_writedata <= '0;
        end else begin
            state            <= state_nxt;
            rr_ptr           <= rr_ptr_nxt;
            grant_id         <= grant_nxt;
            ack              <= ack_nxt;
            busy             <= busy_nxt;
            vga_px_write     <= write_nxt;
            vga_px_address   <= addr_nxt;
            vga_px_writedata <= data_nxt;
        end
    end

endmodule

// File: tb/tb_vga_px_arbiter.sv
// Testbench for vga_px_arbiter (N_REQ=3, ADDR_W=32, DATA_W=16).
// Table of single transactions with hand-computed winners, followed by
// hand-written multi-cycle sequences (fairness, late arrival, mid-write
// deassert, reset mid-write).

module tb_vga_px_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [95:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  ack;
    logic        busy;
    logic [2:0]  grant_id;
    logic [31:0] vga_px_address;
    logic        vga_px_write;
    logic [15:0] vga_px_writedata;
    logic        vga_px_read;
    logic        waitreq;

    int tests  = 0;
    int errors = 0;

    vga_px_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(16)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req                (req),
        .req_addr           (req_addr),
        .req_data           (req_data),
        .ack                (ack),
        .busy               (busy),
        .grant_id           (grant_id),
        .vga_px_address     (vga_px_address),
        .vga_px_write       (vga_px_write),
        .vga_px_writedata   (vga_px_writedata),
        .vga_px_read        (vga_px_read),
        .vga_px_waitrequest (waitreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  r;
        int          waits;
        logic [31:0] abase;
        logic [15:0] dbase;
        logic [2:0]  win;     // pure round-robin
        logic [2:0]  win_p0;  // requester 0 priority build
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Requester i sees address abase + 0x10*i and colour dbase + i.
    task automatic load_slots(input logic [31:0] ab, input logic [15:0] db);
        for (int i = 0; i < 3; i++) begin
            req_addr[i*32 +: 32] = ab + 32'(i * 16);
            req_data[i*16 +: 16] = db + 16'(i);
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = 3'b000;
        waitreq  = 1'b0;
        req_addr = '0;
        req_data = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic run_txn(input logic [2:0] r, input int waits, input logic [31:0] ab,
                           input logic [15:0] db, input logic [2:0] w);
        logic [31:0] ea;
        logic [15:0] ed;
        logic [2:0]  one;
        one = 3'b001;
        ea  = ab + 32'(w) * 32'h10;
        ed  = db + 16'(w);
        load_slots(ab, db);
        req     = r;
        waitreq = (waits > 0);
        @(posedge clk); #1;
        chk("txn_write",  {63'd0, vga_px_write}, 64'd1);
        chk("txn_grant",  {61'd0, grant_id}, {61'd0, w});
        chk("txn_addr",   {32'd0, vga_px_address}, {32'd0, ea});
        chk("txn_data",   {48'd0, vga_px_writedata}, {48'd0, ed});
        chk("txn_busy",   {63'd0, busy}, 64'd1);
        chk("txn_noack",  {61'd0, ack}, 64'd0);
        for (int k = 0; k < waits; k++) begin
            @(posedge clk); #1;
            chk("wait_write", {63'd0, vga_px_write}, 64'd1);
            chk("wait_addr",  {32'd0, vga_px_address}, {32'd0, ea});
            chk("wait_data",  {48'd0, vga_px_writedata}, {48'd0, ed});
            chk("wait_noack", {61'd0, ack}, 64'd0);
            if (k == waits - 1) waitreq = 1'b0;
        end
        @(posedge clk); #1;
        chk("ack_pulse", {61'd0, ack}, {61'd0, one << w});
        chk("ack_write", {63'd0, vga_px_write}, 64'd0);
        chk("ack_busy",  {63'd0, busy}, 64'd1);
        req = 3'b000;
        @(posedge clk); #1;
        chk("idle_ack",  {61'd0, ack}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    // Requests held continuously with a zero-wait slave: a new write every 3 cycles.
    task automatic fair_run(input logic [2:0] r, input logic [2:0] seq [6]);
        logic [2:0] one;
        one = 3'b001;
        load_slots(32'h0000_4000, 16'h0100);
        req     = r;
        waitreq = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk); #1;
            if (e % 3 == 1) begin
                chk("fair_write", {63'd0, vga_px_write}, 64'd1);
                chk("fair_grant", {61'd0, grant_id}, {61'd0, seq[(e-1)/3]});
            end else begin
                chk("fair_nowrite", {63'd0, vga_px_write}, 64'd0);
            end
            if (e % 3 == 2)
                chk("fair_ack", {61'd0, ack}, {61'd0, one << seq[(e-1)/3]});
        end
        req = 3'b000;
        @(posedge clk); #1;
    endtask

    logic [2:0] ew;
    logic [2:0] seq [6];

    initial begin
        vecs[0] = '{3'b001, 0, 32'h0800_1234, 16'hF800, 3'd0, 3'd0};
        vecs[1] = '{3'b010, 4, 32'h0800_2000, 16'h07E0, 3'd1, 3'd1};
        vecs[2] = '{3'b101, 0, 32'h0800_3000, 16'h001F, 3'd2, 3'd0};
        vecs[3] = '{3'b110, 0, 32'h0800_4000, 16'h1234, 3'd1, 3'd2};
        vecs[4] = '{3'b011, 0, 32'h0800_5000, 16'h5555, 3'd0, 3'd0};
        vecs[5] = '{3'b100, 1, 32'h0800_6000, 16'hAAAA, 3'd2, 3'd2};
        vecs[6] = '{3'b111, 0, 32'h0800_7000, 16'h0F0F, 3'd0, 3'd0};
        vecs[7] = '{3'b101, 2, 32'h0800_8000, 16'hF0F0, 3'd2, 3'd0};

        do_reset();
        chk("rst_write", {63'd0, vga_px_write}, 64'd0);
        chk("rst_ack",   {61'd0, ack}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_grant", {61'd0, grant_id}, 64'd0);
        chk("rst_addr",  {32'd0, vga_px_address}, 64'd0);
        chk("rst_data",  {48'd0, vga_px_writedata}, 64'd0);
        chk("rst_read",  {63'd0, vga_px_read}, 64'd0);

        for (int i = 0; i < 8; i++) begin
`ifdef VGA_PX_ARB_PRIO0_EN
            ew = vecs[i].win_p0;
`else
            ew = vecs[i].win;
`endif
            run_txn(vecs[i].r, vecs[i].waits, vecs[i].abase, vecs[i].dbase, ew);
        end

        // Fairness with all three requesting.
        do_reset();
`ifdef VGA_PX_ARB_PRIO0_EN
        seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
        seq = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
`endif
        fair_run(3'b111, seq);

        // Requester 0 idle: 1 and 2 alternate in either build.
        do_reset();
        seq = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2};
        fair_run(3'b110, seq);

        // Late arrival: req[2] rises while requester 0 is writing.
        do_reset();
        load_slots(32'h0900_0000, 16'h0A00);
        req = 3'b001; waitreq = 1'b1;
        @(posedge clk); #1;
        chk("late_g0", {61'd0, grant_id}, 64'd0);
        req = 3'b101;
        @(posedge clk); #1;
        chk("late_hold_write", {63'd0, vga_px_write}, 64'd1);
        chk("late_noack", {61'd0, ack}, 64'd0);
        waitreq = 1'b0;
        @(posedge clk); #1;
        chk("late_ack0", {61'd0, ack}, 64'b001);
        req = 3'b100;
        @(posedge clk); #1;
        chk("late_idle_ack", {61'd0, ack}, 64'd0);
        @(posedge clk); #1;
        chk("late_g2", {61'd0, grant_id}, 64'd2);
        chk("late_g2_addr", {32'd0, vga_px_address}, 64'h0900_0020);
        chk("late_g2_noack", {61'd0, ack}, 64'd0);
        @(posedge clk); #1;
        chk("late_ack2", {61'd0, ack}, 64'b100);
        req = 3'b000;
        @(posedge clk); #1;

        // Winner drops req and changes its slot mid-write: latched values win.
        do_reset();
        load_slots(32'h0A00_0000, 16'h3300);
        req = 3'b010; waitreq = 1'b1;
        @(posedge clk); #1;
        req = 3'b000;
        load_slots(32'h0B00_0000, 16'h7700);
        @(posedge clk); #1;
        chk("drop_addr", {32'd0, vga_px_address}, 64'h0A00_0010);
        chk("drop_data", {48'd0, vga_px_writedata}, 64'h3301);
        chk("drop_write", {63'd0, vga_px_write}, 64'd1);
        waitreq = 1'b0;
        @(posedge clk); #1;
        chk("drop_ack", {61'd0, ack}, 64'b010);
        @(posedge clk); #1;

        // Reset mid-write, with rr_ptr moved off 0 beforehand.
        do_reset();
        run_txn(3'b001, 0, 32'h0C00_0000, 16'h1111, 3'd0);
        load_slots(32'h0D00_0000, 16'h2200);
        req = 3'b100; waitreq = 1'b1;
        @(posedge clk); #1;
        chk("rstw_write", {63'd0, vga_px_write}, 64'd1);
        chk("rstw_grant", {61'd0, grant_id}, 64'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("rstw_write_drop", {63'd0, vga_px_write}, 64'd0);
        chk("rstw_ack",  {61'd0, ack}, 64'd0);
        chk("rstw_busy", {63'd0, busy}, 64'd0);
        chk("rstw_grant0", {61'd0, grant_id}, 64'd0);
        req = 3'b000; waitreq = 1'b0;
        @(posedge clk); #1;
        chk("rstw_noack", {61'd0, ack}, 64'd0);
        reset_n = 1'b1;
        run_txn(3'b011, 0, 32'h0E00_0000, 16'h4400, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
